fetch_queue: RTL and testbench

//  Instruction fetch queue between imem_pc (fetch) and the RV32I decoder.

---
 rtl/fetch_queue.sv | 92 +++++++++
 tb/tb_fetch_queue.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch buffer between the fetch stage and the
// RV32I decoder. Holds {pc, inst, control-flow hint} triples in a small
// circular buffer with valid/ready handshakes on both sides. A synchronous
// flush drops everything on a redirect.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [XLEN-1:0]            in_inst,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_inst,
    output logic                       out_is_branch,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [XLEN-1:0] NOP_INST = XLEN'(32'h0000_0013);

    // Storage has no reset; only the pointers and count define validity.
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [XLEN-1:0] inst_mem [DEPTH];
    logic            br_mem   [DEPTH];

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          push;
    logic          pop;

    // Branch, JAL and JALR opcodes flag an early redirect hint.
    function automatic logic is_ctrl_flow(input logic [6:0] opcode);
        return (opcode == 7'b1100011) || (opcode == 7'b1101111) ||
               (opcode == 7'b1100111);
    endfunction

    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Head entry drives the outputs; an empty queue presents a NOP at pc 0.
    always_comb begin
        out_pc        = '0;
        out_inst      = NOP_INST;
        out_is_branch = 1'b0;
        if (out_valid) begin
            out_pc        = pc_mem[rd_ptr];
            out_inst      = inst_mem[rd_ptr];
            out_is_branch = br_mem[rd_ptr];
        end
    end

    // Write the incoming pair and its pre-decoded hint at the tail.
    always_ff @(posedge CLK) begin
        if (push && !flush) begin
            pc_mem[wr_ptr]   <= in_pc;
            inst_mem[wr_ptr] <= in_inst;
            br_mem[wr_ptr]   <= is_ctrl_flow(in_inst[6:0]);
        end
    end

    // Pointer and occupancy tracking; flush overrides any push or pop.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: expected entries are queued when a push
// is accepted by the model and compared when the head is consumed.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic             CLK = 1'b0;
    logic             RST;
    logic             flush;
    logic             in_valid;
    logic [XLEN-1:0]  in_pc;
    logic [XLEN-1:0]  in_inst;
    logic             in_ready;
    logic             out_valid;
    logic [XLEN-1:0]  out_pc;
    logic [XLEN-1:0]  out_inst;
    logic             out_is_branch;
    logic             out_ready;
    logic [2:0]       count;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        br;
    } entry_t;

    entry_t sb[$];
    int     n_vec = 0;
    int     n_err = 0;
    logic [31:0] pc_next;

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .CLK(CLK), .RST(RST), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready),
        .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
        .out_is_branch(out_is_branch), .out_ready(out_ready), .count(count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic exp_branch(input logic [31:0] inst);
        logic [6:0] op;
        op = inst[6:0];
        return (op == 7'h63) || (op == 7'h6F) || (op == 7'h67);
    endfunction

    // Called at a falling edge: drive, check visible state, then advance one cycle.
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                        input logic ordy, input logic fl);
        logic   e_rdy;
        logic   e_ov;
        entry_t e;
        in_valid  = v;
        in_pc     = pc;
        in_inst   = inst;
        out_ready = ordy;
        flush     = fl;
        #1;
        e_rdy = (sb.size() != DEPTH);
        e_ov  = (sb.size() != 0);
        chk("in_ready", 64'(in_ready), 64'(e_rdy));
        chk("out_valid", 64'(out_valid), 64'(e_ov));
        chk("count", 64'(count), 64'(sb.size()));
        if (e_ov) begin
            chk("out_pc", 64'(out_pc), 64'(sb[0].pc));
            chk("out_inst", 64'(out_inst), 64'(sb[0].inst));
            chk("out_is_branch", 64'(out_is_branch), 64'(sb[0].br));
        end else begin
            chk("empty_pc", 64'(out_pc), 64'h0);
            chk("empty_inst", 64'(out_inst), 64'h13);
            chk("empty_br", 64'(out_is_branch), 64'h0);
        end
        @(posedge CLK);
        if (fl) begin
            sb.delete();
        end else begin
            if (e_ov && ordy) void'(sb.pop_front());
            if (v && e_rdy) begin
                e.pc   = pc;
                e.inst = inst;
                e.br   = exp_branch(inst);
                sb.push_back(e);
            end
        end
        @(negedge CLK);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [6:0]  ops [6];
        ops = '{7'h63, 7'h6F, 7'h67, 7'h13, 7'h33, 7'h03};
        r = $urandom;
        return {r[31:7], ops[$urandom_range(0, 5)]};
    endfunction

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 50) begin
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            guard++;
        end
        chk("drain_done", 64'(sb.size()), 64'h0);
    endtask

    initial begin
        RST = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b0;

        // 1: reset state
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_in_ready", 64'(in_ready), 64'h1);
        chk("rst_count", 64'(count), 64'h0);
        chk("rst_out_inst", 64'(out_inst), 64'h13);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // 2: fill with out_ready low, then drain in order
        step(1'b1, 32'h0, 32'h00500093, 1'b0, 1'b0);
        step(1'b1, 32'h4, 32'h00100113, 1'b0, 1'b0);
        step(1'b1, 32'h8, 32'h002081B3, 1'b0, 1'b0);
        step(1'b1, 32'hC, 32'h0000006F, 1'b0, 1'b0);
        #1;
        chk("full_count", 64'(count), 64'h4);
        chk("full_in_ready", 64'(in_ready), 64'h0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        #1;
        chk("jal_head_pc", 64'(out_pc), 64'hC);
        chk("jal_head_br", 64'(out_is_branch), 64'h1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // 3: streaming with both sides active
        pc_next = 32'h100;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, pc_next, rand_inst(), 1'b1, 1'b0);
            pc_next += 4;
            #1;
            chk("stream_count", 64'(count), 64'h1);
        end
        drain();

        // 4: full queue with simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, pc_next, rand_inst(), 1'b0, 1'b0);
            pc_next += 4;
        end
        step(1'b1, 32'hDEAD0000, 32'h00000013, 1'b1, 1'b0);
        #1;
        chk("fullpop_count", 64'(count), 64'h3);
        chk("fullpop_in_ready", 64'(in_ready), 64'h1);

        // 5: flush with a concurrent push
        step(1'b1, 32'hBEEF0000, 32'h00000063, 1'b0, 1'b1);
        #1;
        chk("flush_count", 64'(count), 64'h0);
        chk("flush_out_valid", 64'(out_valid), 64'h0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // 6: randomized traffic across pointer wrap
        begin
            int pushed;
            int guard;
            pushed = 0;
            guard  = 0;
            while (pushed < 2*DEPTH+1 && guard < 200) begin
                logic v;
                logic r;
                v = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 2) != 0);
                if (v && sb.size() != DEPTH) pushed++;
                step(v, pc_next, rand_inst(), r, 1'b0);
                if (v) pc_next += 4;
                guard++;
            end
            chk("wrap_pushed", 64'(pushed), 64'(2*DEPTH+1));
            drain();
        end

        // mid-stream asynchronous reset
        step(1'b1, pc_next, rand_inst(), 1'b0, 1'b0);
        step(1'b1, pc_next + 4, rand_inst(), 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        RST = 1'b0;
        #1;
        chk("async_rst_count", 64'(count), 64'h0);
        chk("async_rst_out_valid", 64'(out_valid), 64'h0);
        sb.delete();
        @(negedge CLK);
        RST = 1'b1;
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
